// File: rtl/crc_pkg.sv
// Shared definitions for the CRC frame receiver.
//   state_e    : receiver FSM states
//   CRC32_POLY : default CRC-32 generator, explicit x^32 term at the MSB
//   CRC_INIT   : residue start value (non-reflected, no final XOR)
package crc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam logic [32:0] CRC32_POLY = 33'h104C11DB7;
    localparam logic [31:0] CRC_INIT   = 32'h0000_0000;

endpackage

// File: rtl/crc_shift_core.sv
// Bit-serial CRC engine: one received word is shifted in MSB first, one bit
// per enabled cycle, through a Galois-style LFSR.
//   load/clr/data_i : load a new word; clr also restarts the residue
//   en              : perform one bit step
//   poly_i          : generator polynomial without the implicit x^WIDTH term
//   residue_o       : current remainder
//   residue_nxt_o   : remainder after the current cycle's update
//   last_bit_o      : this enabled cycle consumes the word's final bit
module crc_shift_core
    import crc_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             clr,
    input  logic [WIDTH-1:0] data_i,
    input  logic             en,
    input  logic [WIDTH-1:0] poly_i,
    output logic [WIDTH-1:0] residue_o,
    output logic [WIDTH-1:0] residue_nxt_o,
    output logic             last_bit_o
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [WIDTH-1:0] sr_q, sr_d;
    logic [WIDTH-1:0] residue_q, residue_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] step;
    logic             fb;

    always_comb begin
        fb        = residue_q[WIDTH-1] ^ sr_q[WIDTH-1];
        step      = {residue_q[WIDTH-2:0], 1'b0} ^ (fb ? poly_i : '0);
        sr_d      = sr_q;
        residue_d = residue_q;
        cnt_d     = cnt_q;
        if (load) begin
            sr_d  = data_i;
            cnt_d = '0;
            if (clr) begin
                residue_d = WIDTH'(CRC_INIT);
            end
        end else if (en) begin
            sr_d      = {sr_q[WIDTH-2:0], 1'b0};
            residue_d = step;
            cnt_d     = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            sr_q      <= '0;
            residue_q <= '0;
            cnt_q     <= '0;
        end else begin
            sr_q      <= sr_d;
            residue_q <= residue_d;
            cnt_q     <= cnt_d;
        end
    end

    assign residue_o     = residue_q;
    assign residue_nxt_o = residue_d;
    assign last_bit_o    = en && (cnt_q == CW'(WIDTH - 1));

endmodule

// File: rtl/crc32_frame_rx.sv
// CRC frame receiver: accepts a frame of WIDTH-bit words (data words, then
// the transmitted CRC word flagged by in_last), runs every word through a
// bit-serial CRC engine and reports pass/fail and length errors.
//   clk, rst          : clock, synchronous active-low reset
//   in_data/valid/last: word stream; accepted only while in_ready=1
//   polynom_i         : generator, sampled on a frame's first word
//   residue           : running remainder (0 after a correct frame)
//   word_cnt          : words accepted in the current frame
//   done              : one-cycle frame-complete pulse
//   ok, len_err       : frame verdict, held until the next frame starts
module crc32_frame_rx
    import crc_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int MAX_LEN = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [WIDTH-1:0]               in_data,
    input  logic                           in_valid,
    input  logic                           in_last,
    output logic                           in_ready,
    input  logic [WIDTH:0]                 polynom_i,
    output logic [WIDTH-1:0]               residue,
    output logic [$clog2(MAX_LEN+1)-1:0]   word_cnt,
    output logic                           done,
    output logic                           ok,
    output logic                           len_err
);

    localparam int CNT_W = $clog2(MAX_LEN + 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] poly_q, poly_d;
    logic             last_q, last_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ok_q, ok_d;
    logic             len_err_q, len_err_d;
    logic             rdy_en_q, rdy_en_d;

    logic             load, clr, en, last_bit, len_err_now;
    logic [WIDTH-1:0] res_nxt;

    crc_shift_core #(.WIDTH(WIDTH)) u_core (
        .clk           (clk),
        .rst           (rst),
        .load          (load),
        .clr           (clr),
        .data_i        (in_data),
        .en            (en),
        .poly_i        (poly_q),
        .residue_o     (residue),
        .residue_nxt_o (res_nxt),
        .last_bit_o    (last_bit)
    );

    always_comb begin
        state_d     = state_q;
        poly_d      = poly_q;
        last_d      = last_q;
        cnt_d       = cnt_q;
        ok_d        = ok_q;
        len_err_d   = len_err_q;
        rdy_en_d    = 1'b1;
        load        = 1'b0;
        clr         = 1'b0;
        en          = 1'b0;
        // Too short (CRC word only) or ran out of room without a CRC marker.
        len_err_now = (last_q && (cnt_q == CNT_W'(1))) || !last_q;
        case (state_q)
            IDLE: begin
                if (in_valid && rdy_en_q) begin
                    load    = 1'b1;
                    last_d  = in_last;
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = SHIFT;
                    if (cnt_q == '0) begin
                        clr       = 1'b1;
                        poly_d    = polynom_i[WIDTH-1:0];
                        ok_d      = 1'b0;
                        len_err_d = 1'b0;
                    end
                end
            end
            SHIFT: begin
                en = 1'b1;
                if (last_bit) begin
                    if (last_q || (cnt_q == CNT_W'(MAX_LEN))) begin
                        // Verdict uses the remainder after the final bit so it
                        // is already valid while done is high.
                        state_d   = DONE;
                        len_err_d = len_err_now;
                        ok_d      = (res_nxt == '0) && !len_err_now;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            poly_q    <= WIDTH'(CRC32_POLY);
            last_q    <= 1'b0;
            cnt_q     <= '0;
            ok_q      <= 1'b0;
            len_err_q <= 1'b0;
            rdy_en_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            poly_q    <= poly_d;
            last_q    <= last_d;
            cnt_q     <= cnt_d;
            ok_q      <= ok_d;
            len_err_q <= len_err_d;
            rdy_en_q  <= rdy_en_d;
        end
    end

    // rdy_en_q keeps in_ready low during reset and for the first cycle after.
    assign in_ready = (state_q == IDLE) && rdy_en_q;
    assign done     = (state_q == DONE);
    assign word_cnt = cnt_q;
    assign ok       = ok_q;
    assign len_err  = len_err_q;

endmodule

// File: tb/tb_crc32_frame_rx.sv
module tb_crc32_frame_rx;
    import crc_pkg::*;

    localparam int WIDTH   = 32;
    localparam int MAX_LEN = 4;
    localparam int CNT_W   = $clog2(MAX_LEN + 1);

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [WIDTH-1:0]  in_data = '0;
    logic              in_valid = 1'b0;
    logic              in_last = 1'b0;
    logic              in_ready;
    logic [WIDTH:0]    polynom_i = CRC32_POLY;
    logic [WIDTH-1:0]  residue;
    logic [CNT_W-1:0]  word_cnt;
    logic              done;
    logic              ok;
    logic              len_err;

    crc32_frame_rx #(.WIDTH(WIDTH), .MAX_LEN(MAX_LEN)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .polynom_i (polynom_i),
        .residue   (residue),
        .word_cnt  (word_cnt),
        .done      (done),
        .ok        (ok),
        .len_err   (len_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_pass = 0;
    int acc_cyc = 0;
    int done_cyc = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Present one word once the DUT is ready; returns at the negedge after acceptance.
    task automatic send(input logic [WIDTH-1:0] d, input logic l);
        int n;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("ready_wait", in_ready, 1);
        in_data  = d;
        in_last  = l;
        in_valid = 1'b1;
        @(negedge clk);
        acc_cyc  = cyc;
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = $urandom;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (!done && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("done_seen", done, 1);
        done_cyc = cyc;
    endtask

    int first_cyc, lowc, n, done_hits;
    logic got_done, ok_s, lerr_s;
    logic [CNT_W-1:0] cnt_s;

    initial begin
        // Reset state
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_residue", residue, 0);
        chk("rst_word_cnt", word_cnt, 0);
        chk("rst_done", done, 0);
        chk("rst_ok", ok, 0);
        chk("rst_len_err", len_err, 0);
        rst = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", in_ready, 1);

        // Good frame: x^0 then x^32 mod P -> remainder 0
        send(32'h0000_0001, 1'b0);
        first_cyc = acc_cyc - 1;
        chk("good_cnt1", word_cnt, 1);
        send(32'h04C1_1DB7, 1'b1);
        wait_done();
        chk("good_latency", done_cyc - first_cyc, 2 * (WIDTH + 1));
        chk("good_ok", ok, 1);
        chk("good_residue", residue, 0);
        chk("good_len_err", len_err, 0);
        chk("good_cnt_at_done", word_cnt, 2);
        repeat (3) @(negedge clk);
        chk("hold_done_low", done, 0);
        chk("hold_ok", ok, 1);
        chk("hold_residue", residue, 0);
        chk("hold_cnt_cleared", word_cnt, 0);

        // Corrupted CRC word: residue = x^32 mod P
        send(32'h0000_0001, 1'b0);
        chk("bad_ok_cleared", ok, 0);
        send(32'h04C1_1DB6, 1'b1);
        wait_done();
        chk("bad_ok", ok, 0);
        chk("bad_residue", residue, 32'h04C1_1DB7);
        chk("bad_len_err", len_err, 0);

        // Alternate polynomial x^32+x^2+x+1, changed back mid-frame
        polynom_i = 33'h1_0000_0007;
        send(32'h0000_0001, 1'b0);
        polynom_i = CRC32_POLY;
        send(32'h0000_0007, 1'b1);
        wait_done();
        chk("poly_ok", ok, 1);
        chk("poly_residue", residue, 0);

        // Single-word frame is a length error
        send(32'hDEAD_BEEF, 1'b1);
        wait_done();
        chk("single_latency", done_cyc - acc_cyc, WIDTH);
        chk("single_len_err", len_err, 1);
        chk("single_ok", ok, 0);
        chk("single_cnt", word_cnt, 1);

        // MAX_LEN words without in_last
        send(32'h0, 1'b0);
        send(32'h0, 1'b0);
        send(32'h0, 1'b0);
        send(32'h1, 1'b0);
        wait_done();
        chk("max_latency", done_cyc - acc_cyc, WIDTH);
        chk("max_len_err", len_err, 1);
        chk("max_cnt", word_cnt, 4);
        chk("max_ok", ok, 0);
        chk("max_residue", residue, 32'h04C1_1DB7);

        // in_valid held high with garbage while busy
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 200) begin @(negedge clk); n++; end
        in_valid = 1'b1; in_data = 32'h1; in_last = 1'b0;
        @(negedge clk);
        n = 0;
        while (!in_ready && n < 200) begin
            in_data = $urandom; in_last = 1'($urandom_range(0, 1));
            @(negedge clk); n++;
        end
        chk("busy_cnt1", word_cnt, 1);
        in_data = 32'h04C1_1DB7; in_last = 1'b1;
        @(negedge clk);
        lowc = 0; got_done = 1'b0; ok_s = 1'b0; lerr_s = 1'b1; cnt_s = '0;
        while (!in_ready && lowc < 200) begin
            if (done) begin got_done = 1'b1; ok_s = ok; lerr_s = len_err; cnt_s = word_cnt; end
            in_data = $urandom; in_last = 1'($urandom_range(0, 1));
            @(negedge clk); lowc++;
        end
        in_valid = 1'b0; in_last = 1'b0;
        chk("busy_low_cycles", lowc, WIDTH + 1);
        chk("busy_done", got_done, 1);
        chk("busy_ok", ok_s, 1);
        chk("busy_len_err", lerr_s, 0);
        chk("busy_cnt_at_done", cnt_s, 2);
        repeat (2) @(negedge clk);
        chk("busy_no_extra", word_cnt, 0);

        // Reset at shift bit 10 of word 1 aborts the frame
        send(32'h1234_5678, 1'b0);
        repeat (10) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("abort_residue", residue, 0);
        chk("abort_cnt", word_cnt, 0);
        chk("abort_done", done, 0);
        chk("abort_ok", ok, 0);
        chk("abort_len_err", len_err, 0);
        chk("abort_in_ready", in_ready, 0);
        @(negedge clk);
        rst = 1'b1;
        done_hits = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) done_hits++;
        end
        chk("abort_no_done", done_hits, 0);
        chk("abort_ready", in_ready, 1);
        send(32'h0, 1'b0);
        send(32'h0, 1'b1);
        wait_done();
        chk("post_abort_ok", ok, 1);
        chk("post_abort_residue", residue, 0);
        chk("post_abort_len_err", len_err, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
